// File: rtl/lfsr_enc_pkg.sv
// Shared types and default constants for the LFSR encryption sequencer.
package lfsr_enc_pkg;

  typedef enum logic [2:0] {
    IDLE,
    RD_PRE,
    RD_TAPS,
    RD_SEED,
    LOAD,
    PREAMBLE,
    MESSAGE,
    DONE
  } enc_state_t;

  localparam int unsigned DEF_MSG_LEN  = 50;
  localparam int unsigned DEF_SRC_BASE = 0;
  localparam int unsigned DEF_CFG_BASE = 61;
  localparam int unsigned DEF_DST_BASE = 64;
  localparam logic [7:0]  DEF_PRE_CHAR = 8'h5F;

  // Longest preamble that keeps the last ciphertext byte at or below 8'hFF.
  function automatic int unsigned max_pre(input int unsigned dst_base,
                                          input int unsigned msg_len);
    return 256 - dst_base - msg_len;
  endfunction

endpackage

// File: rtl/lfsr_encrypt_ctrl.sv
// Sequencer for the encryption datapath: reads the config words from dat_mem,
// loads lfsr6, writes the encrypted preamble and message, then pulses done.
module lfsr_encrypt_ctrl
  import lfsr_enc_pkg::*;
#(
  parameter int unsigned MSG_LEN  = DEF_MSG_LEN,
  parameter int unsigned SRC_BASE = DEF_SRC_BASE,
  parameter int unsigned CFG_BASE = DEF_CFG_BASE,
  parameter int unsigned DST_BASE = DEF_DST_BASE,
  parameter logic [7:0]  PRE_CHAR = DEF_PRE_CHAR
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  output logic       busy,
  output logic       done,
  output logic       cfg_err,
  output logic [7:0] raddr,
  output logic [7:0] waddr,
  output logic       write_en,
  output logic [7:0] data_in,
  input  logic [7:0] data_out,
  output logic       lfsr_en,
  output logic       lfsr_load,
  output logic [5:0] taps,
  output logic [5:0] seed,
  input  logic [5:0] lfsr_state
);

  localparam logic [7:0] MAX_PRE  = 8'(max_pre(DST_BASE, MSG_LEN));
  localparam logic [7:0] LAST_MSG = 8'(MSG_LEN - 1);
  localparam logic [7:0] SRC_B    = 8'(SRC_BASE);
  localparam logic [7:0] DST_B    = 8'(DST_BASE);
  localparam logic [7:0] CFG_PRE  = 8'(CFG_BASE);
  localparam logic [7:0] CFG_TAPS = 8'(CFG_BASE + 1);
  localparam logic [7:0] CFG_SEED = 8'(CFG_BASE + 2);

  enc_state_t state;
  logic [7:0] pre_len;
  logic [7:0] wptr;
  logic [7:0] msg_idx;

  // Control FSM; write_en/lfsr_en/lfsr_load/done are set on the edge that
  // enters the state in which they must be high.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      busy      <= 1'b0;
      done      <= 1'b0;
      cfg_err   <= 1'b0;
      write_en  <= 1'b0;
      lfsr_en   <= 1'b0;
      lfsr_load <= 1'b0;
      taps      <= '0;
      seed      <= '0;
      pre_len   <= '0;
      wptr      <= '0;
      msg_idx   <= '0;
    end else begin
      done      <= 1'b0;
      lfsr_load <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state   <= RD_PRE;
            busy    <= 1'b1;
            cfg_err <= 1'b0;
          end
        end
        RD_PRE: begin
          if (data_out > MAX_PRE) begin
            pre_len <= MAX_PRE;
            cfg_err <= 1'b1;
          end else begin
            pre_len <= data_out;
          end
          state <= RD_TAPS;
        end
        RD_TAPS: begin
          taps <= data_out[5:0];
          if (data_out[5:0] == 6'd0) cfg_err <= 1'b1;
          state <= RD_SEED;
        end
        RD_SEED: begin
          seed <= data_out[5:0];
          if (data_out[5:0] == 6'd0) cfg_err <= 1'b1;
          lfsr_load <= 1'b1;
          state     <= LOAD;
        end
        LOAD: begin
          wptr     <= '0;
          msg_idx  <= '0;
          write_en <= 1'b1;
          lfsr_en  <= 1'b1;
          state    <= (pre_len != '0) ? PREAMBLE : MESSAGE;
        end
        PREAMBLE: begin
          wptr <= wptr + 8'd1;
          if (wptr == pre_len - 8'd1) state <= MESSAGE;
        end
        MESSAGE: begin
          wptr    <= wptr + 8'd1;
          msg_idx <= msg_idx + 8'd1;
          if (msg_idx == LAST_MSG) begin
            state    <= DONE;
            write_en <= 1'b0;
            lfsr_en  <= 1'b0;
            done     <= 1'b1;
          end
        end
        DONE: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Memory addressing and write data; data_out is combinational from raddr,
  // so ciphertext is formed in the same cycle as the read.
  always_comb begin
    raddr   = '0;
    waddr   = DST_B;
    data_in = '0;
    case (state)
      RD_PRE:  raddr = CFG_PRE;
      RD_TAPS: raddr = CFG_TAPS;
      RD_SEED: raddr = CFG_SEED;
      PREAMBLE: begin
        waddr   = DST_B + wptr;
        data_in = PRE_CHAR ^ {2'b00, lfsr_state};
      end
      MESSAGE: begin
        raddr   = SRC_B + msg_idx;
        waddr   = DST_B + wptr;
        data_in = data_out ^ {2'b00, lfsr_state};
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_lfsr_encrypt_ctrl.sv
// Bench for lfsr_encrypt_ctrl with behavioural dat_mem/lfsr6 and a reference
// model computing the expected ciphertext image from the config words.
module tb_lfsr_encrypt_ctrl;
  import lfsr_enc_pkg::*;

  localparam int MLEN = 50;
  localparam int DSTB = 64;
  localparam int MAXP = 256 - DSTB - MLEN;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic       busy, done, cfg_err;
  logic [7:0] raddr, waddr, data_in, data_out;
  logic       write_en, lfsr_en, lfsr_load;
  logic [5:0] taps, seed, lfsr_state;

  logic [7:0] mem [256];
  logic [7:0] img [256];
  logic [7:0] basic_mem [256];
  logic       load_req;
  logic [5:0] lfsr_taps;

  int n_assert = 0;
  int n_fail   = 0;
  int wr_cnt   = 0;
  int low_wr   = 0;
  int done_cnt = 0;
  int last_waddr = -1;

  always #5 clk = ~clk;

  lfsr_encrypt_ctrl #(
    .MSG_LEN (50),
    .SRC_BASE(0),
    .CFG_BASE(61),
    .DST_BASE(64),
    .PRE_CHAR(8'h5F)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .busy      (busy),
    .done      (done),
    .cfg_err   (cfg_err),
    .raddr     (raddr),
    .waddr     (waddr),
    .write_en  (write_en),
    .data_in   (data_in),
    .data_out  (data_out),
    .lfsr_en   (lfsr_en),
    .lfsr_load (lfsr_load),
    .taps      (taps),
    .seed      (seed),
    .lfsr_state(lfsr_state)
  );

  function automatic logic [5:0] lfsr_next(input logic [5:0] s, input logic [5:0] t);
    return {s[4:0], ^(s & t)};
  endfunction

  assign data_out = mem[raddr];

  // dat_mem: bulk image load from the bench, otherwise DUT writes
  always @(posedge clk) begin
    if (load_req) begin
      for (int i = 0; i < 256; i++) mem[i] <= img[i];
    end else if (write_en) begin
      mem[waddr] <= data_in;
    end
  end

  // write log
  always @(posedge clk) begin
    if (write_en && !load_req) begin
      wr_cnt = wr_cnt + 1;
      last_waddr = int'(waddr);
      if (int'(waddr) < DSTB) low_wr = low_wr + 1;
    end
  end

  always @(negedge clk) if (done) done_cnt = done_cnt + 1;

  // lfsr6
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lfsr_state <= '0;
      lfsr_taps  <= '0;
    end else if (lfsr_load) begin
      lfsr_state <= seed;
      lfsr_taps  <= taps;
    end else if (lfsr_en) begin
      lfsr_state <= lfsr_next(lfsr_state, lfsr_taps);
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic do_run(input logic [7:0] pre_raw, input logic [7:0] tp, input logic [7:0] sd,
                        input int start2_at, input int rst_at, input bit reuse_img);
    int pre_eff, cyc, d0, w0, l0, nmis;
    logic [5:0] s;
    logic [7:0] exp_mem [256];
    logic exp_err;
    if (!reuse_img)
      for (int i = 0; i < 256; i++) img[i] = 8'($urandom);
    img[61] = pre_raw;
    img[62] = tp;
    img[63] = sd;
    @(negedge clk) load_req = 1'b1;
    @(negedge clk) load_req = 1'b0;

    pre_eff = (int'(pre_raw) > MAXP) ? MAXP : int'(pre_raw);
    exp_err = (int'(pre_raw) > MAXP) || (tp[5:0] == 6'd0) || (sd[5:0] == 6'd0);
    exp_mem = img;
    s = sd[5:0];
    for (int k = 0; k < pre_eff; k++) begin
      exp_mem[DSTB + k] = 8'h5F ^ {2'b00, s};
      s = lfsr_next(s, tp[5:0]);
    end
    for (int m = 0; m < MLEN; m++) begin
      exp_mem[DSTB + pre_eff + m] = img[m] ^ {2'b00, s};
      s = lfsr_next(s, tp[5:0]);
    end

    d0 = done_cnt; w0 = wr_cnt; l0 = low_wr;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cyc = 1;
    chk("busy_after_start", 32'(busy), 32'(1));
    while (!done && cyc < 400) begin
      start = (cyc == start2_at);
      if (cyc == rst_at) begin
        chk("we_before_reset", 32'(write_en), 32'(1));
        #2 rst_n = 1'b0;
        #1;
        chk("rst_write_en", 32'(write_en), 32'(0));
        chk("rst_busy", 32'(busy), 32'(0));
        chk("rst_lfsr_en", 32'(lfsr_en), 32'(0));
        chk("rst_raddr", 32'(raddr), 32'(0));
        chk("rst_waddr", 32'(waddr), 32'(DSTB));
        chk("rst_state", 32'(dut.state), 32'(IDLE));
        @(negedge clk);
        rst_n = 1'b1;
        start = 1'b0;
        return;
      end
      @(negedge clk);
      cyc++;
    end
    start = 1'b0;
    chk("done_seen", 32'(done), 32'(1));
    chk("latency", 32'(cyc), 32'(5 + pre_eff + MLEN));
    chk("cfg_err", 32'(cfg_err), 32'(exp_err));
    @(negedge clk);
    chk("done_one_cycle", 32'(done), 32'(0));
    chk("busy_clear", 32'(busy), 32'(0));
    chk("done_count", 32'(done_cnt - d0), 32'(1));
    chk("write_count", 32'(wr_cnt - w0), 32'(pre_eff + MLEN));
    chk("low_writes", 32'(low_wr - l0), 32'(0));
    chk("last_waddr", 32'(last_waddr), 32'(DSTB + pre_eff + MLEN - 1));
    nmis = 0;
    for (int i = 0; i < 256; i++) if (mem[i] !== exp_mem[i]) nmis++;
    chk("mem_image", 32'(nmis), 32'(0));
  endtask

  initial begin
    int nbad;
    rst_n = 1'b0;
    start = 1'b0;
    load_req = 1'b0;
    repeat (2) @(negedge clk);
    chk("reset_busy", 32'(busy), 32'(0));
    chk("reset_done", 32'(done), 32'(0));
    chk("reset_cfg_err", 32'(cfg_err), 32'(0));
    chk("reset_write_en", 32'(write_en), 32'(0));
    chk("reset_lfsr_en", 32'(lfsr_en), 32'(0));
    chk("reset_lfsr_load", 32'(lfsr_load), 32'(0));
    chk("reset_taps", 32'(taps), 32'(0));
    chk("reset_seed", 32'(seed), 32'(0));
    chk("reset_raddr", 32'(raddr), 32'(0));
    chk("reset_waddr", 32'(waddr), 32'(DSTB));
    chk("reset_data_in", 32'(data_in), 32'(0));
    rst_n = 1'b1;
    @(negedge clk);

    // basic run
    do_run(8'd7, 8'h21, 8'h01, 0, 0, 1'b0);
    chk("basic_mem64", 32'(mem[64]), 32'(8'h5E));
    basic_mem = mem;

    // no preamble
    do_run(8'd0, 8'h21, 8'h2D, 0, 0, 1'b0);
    chk("pre0_first_write", 32'(mem[64]), 32'(img[0] ^ 8'h2D));

    // oversized preamble gets clamped
    do_run(8'd200, 8'h33, 8'h15, 0, 0, 1'b0);
    chk("clamp_last_addr", 32'(last_waddr), 32'(255));

    // second start mid-run, same image as the basic run
    for (int i = 0; i < 256; i++) img[i] = basic_mem[i];
    for (int i = DSTB; i < 256; i++) img[i] = 8'h00;
    do_run(8'd7, 8'h21, 8'h01, 24, 0, 1'b1);
    nbad = 0;
    for (int i = 0; i < DSTB + 7 + MLEN; i++) if (mem[i] !== basic_mem[i]) nbad++;
    chk("start_ignored_mem", 32'(nbad), 32'(0));

    // asynchronous reset at MESSAGE byte 10, then a fresh run
    do_run(8'd7, 8'h21, 8'h01, 0, 5 + 7 + 10, 1'b0);
    do_run(8'd7, 8'h21, 8'h01, 0, 0, 1'b0);

    // zero seed: preamble is the bare character
    do_run(8'd9, 8'h21, 8'h00, 0, 0, 1'b0);
    nbad = 0;
    for (int k = 0; k < 9; k++) if (mem[DSTB + k] !== 8'h5F) nbad++;
    chk("zero_seed_preamble", 32'(nbad), 32'(0));

    // randomized configurations
    for (int r = 0; r < 4; r++)
      do_run(8'($urandom_range(0, 170)), 8'($urandom), 8'($urandom), 0, 0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
